alu_sequencer: RTL and testbench
================================

# alu_sequencer

Program-driven controller for the 8-bit combinational ALU (ops: 0 add, 1 sub, 2 and, 3 or). It holds a small instruction memory and an accumulator. It drives the ALU operand and op inputs, captures the ALU result back into the accumulator, and steps through the program until HALT or the end of memory. It sits on the initiator side of the ALU's a/b/op → c interface, with the ALU instantiated beside it at the top level.

## Interface
- DEPTH, 16, instruction memory entries (power of two; PC width = log2(DEPTH))
- W, 8, data / accumulator width (must match the ALU)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- prog_we  input  1  program write strobe
- prog_addr  input  log2(DEPTH)  program write address
- prog_data  input  W+4  instruction word
- start  input  1  begin execution at address 0
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse at the end of a run
- acc  output  W  accumulator value
- alu_a  output  W  ALU operand a = acc
- alu_b  output  W  ALU operand b = ir[W-1:0]
- alu_op  output  2  ALU op = ir[W+1:W]
- alu_c  input  W  ALU result (combinational from alu_a/alu_b/alu_op)

## Operation
- Instruction word: [W+3:W+2] class, [W+1:W] alu op, [W-1:0] immediate.
- Class encoding:
  - 00 LDI: acc ← imm.
  - 01 ALU: acc ← alu_c, i.e. acc op imm.
  - 10 HALT.
  - 11 NOP.
- FSM states: IDLE, FETCH, EXEC, DONE.
- IDLE:
  - start=1 → pc ← 0, go to FETCH.
  - prog_we=1 → mem[prog_addr] ← prog_data. Program writes are accepted only in IDLE.
- FETCH: ir ← mem[pc] (registered read), go to EXEC.
- EXEC: perform the instruction.
  - HALT → DONE; pc is not incremented.
  - Any other class, if pc = DEPTH-1 → DONE after executing.
  - Otherwise pc ← pc+1, go to FETCH.
- DONE: done=1 for this cycle, then go to IDLE.
- Arithmetic is modulo 2^W; the ALU wraps, and this block adds no carry or flags.
- start while busy: ignored. prog_we while busy: ignored, memory unchanged.
- alu_a, alu_b and alu_op come straight from registers (acc, ir). They are stable throughout EXEC, so alu_c is valid by the EXEC edge.

## Timing
- Reset values:
  - state = IDLE, pc = 0, acc = 0, ir = 12'h800 (HALT, zero immediate).
  - busy = 0, done = 0, alu_a = 0, alu_b = 0, alu_op = 0.
  - Every memory word = HALT (class 10, other bits 0).
- Reset mid-run: returns to IDLE immediately and asynchronously, with all values above restored. Program contents are lost (reset to HALT).
- Latency:
  - Each instruction takes 2 cycles (FETCH + EXEC).
  - With start sampled at edge 0, instruction i updates acc at edge 2i+2.
  - A program whose HALT sits at index N-1 enters DONE at edge 2N. done is high in the following cycle, and the block is back in IDLE at edge 2N+1.
  - Without a HALT, DONE is entered at edge 2·DEPTH.
- busy goes high at edge 0 and stays high through the DONE cycle.
- acc is held after done until the next LDI/ALU instruction or reset. A new start does not clear acc.
- start held high continuously: a new run begins on the first IDLE cycle after DONE.

## Test plan
- Reset then idle: all outputs 0, busy=0. A start with the memory in its reset state → done at edge 2 (HALT at index 0), acc=0.
- Program LDI 7; ALU add 3; ALU sub 3; ALU and 3; ALU or 12; HALT, then start:
  - acc after each EXEC is 7, 10, 7, 3, 15.
  - done pulses exactly one cycle, at edge 12.
  - alu_a/alu_b/alu_op match the register values during each EXEC.
- Wrap-around:
  - LDI 0; sub 1 → acc=255.
  - LDI 250; add 10 → acc=4.
- No HALT: 16 × NOP with word 0 = LDI 5 → done at edge 32, acc=5, pc does not wrap to a second pass.
- While busy:
  - Pulse start → ignored, run timing unchanged.
  - prog_we to address 3 → ignored; a later read of word 3 shows the old value.
- Assert rst mid-run (during EXEC of instruction 2) → immediately busy=0, acc=0. A start afterwards with no reprogramming → done at edge 2.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: program-driven controller for an external W-bit ALU (add/sub/and/or).
// Steps LDI/ALU/HALT/NOP words from a small memory, accumulating results in acc.
module alu_sequencer #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [W+3:0]             prog_data,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [W-1:0]             acc,
   output logic [W-1:0]             alu_a,
   output logic [W-1:0]             alu_b,
   output logic [1:0]               alu_op,
   input  logic [W-1:0]             alu_c,
   output logic [1:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [1:0] C_LDI  = 2'b00;
   localparam logic [1:0] C_ALU  = 2'b01;
   localparam logic [1:0] C_HALT = 2'b10;

   localparam logic [W+3:0]  HALT_WORD = {C_HALT, {(W+2){1'b0}}};
   localparam logic [AW-1:0] PC_LAST   = AW'(DEPTH - 1);

   logic [1:0]    r_state;
   logic [AW-1:0] r_pc;
   logic [W-1:0]  r_acc;
   logic [W+3:0]  r_ir;
   logic [W+3:0]  r_mem [DEPTH];
   logic [1:0]    w_class;

   assign w_class = r_ir[W+3:W+2];

   // ALU operands come straight from registers so alu_c settles within EXEC.
   assign alu_a     = r_acc;
   assign alu_b     = r_ir[W-1:0];
   assign alu_op    = r_ir[W+1:W];
   assign acc       = r_acc;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign dbg_state = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_acc   <= '0;
         r_ir    <= HALT_WORD;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i[AW-1:0]] <= HALT_WORD;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (prog_we) begin
                  r_mem[prog_addr] <= prog_data;
               end
               if (start) begin
                  r_pc    <= '0;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               r_ir    <= r_mem[r_pc];
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               if (w_class == C_LDI) begin
                  r_acc <= r_ir[W-1:0];
               end else if (w_class == C_ALU) begin
                  r_acc <= alu_c;
               end
               // HALT leaves pc on the HALT word; the last word ends the run without wrapping.
               if (w_class == C_HALT || r_pc == PC_LAST) begin
                  r_state <= S_DONE;
               end else begin
                  r_pc    <= r_pc + AW'(1);
                  r_state <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU beside it and an
// expected-accumulator queue checked after every executed instruction.
module tb_alu_sequencer;

   localparam int DEPTH = 16;
   localparam int W     = 8;
   localparam int AW    = 4;

   logic          clk;
   logic          rst;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [W+3:0]  prog_data;
   logic          start;
   logic          busy;
   logic          done;
   logic [W-1:0]  acc;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic [1:0]    alu_op;
   logic [W-1:0]  alu_c;
   logic [1:0]    dbg_state;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int cyc0     = 0;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  exp_acc;
   logic [W+3:0]  pg [DEPTH];
   int            pg_len;

   alu_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .busy(busy), .done(done),
      .acc(acc), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_c(alu_c), .dbg_state(dbg_state)
   );

   // Behavioural ALU sitting beside the sequencer.
   always_comb begin
      alu_c = '0;
      case (alu_op)
         2'd0: alu_c = alu_a + alu_b;
         2'd1: alu_c = alu_a - alu_b;
         2'd2: alu_c = alu_a & alu_b;
         default: alu_c = alu_a | alu_b;
      endcase
   end

   // Clock/reset block.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W+3:0] mk(input logic [1:0] c, input logic [1:0] op,
                                       input logic [W-1:0] imm);
      return {c, op, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_prog();
      for (int i = 0; i < pg_len; i++) begin
         prog_we   = 1'b1;
         prog_addr = AW'(i);
         prog_data = pg[i];
         tick(1);
      end
      prog_we = 1'b0;
   endtask

   // Start a run and follow it instruction by instruction.
   task automatic run_prog(input string name, input int n_exec, input int done_edge,
                           input bit poke);
      logic [W-1:0] e;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      cyc0  = cyc;
      chk({name, "_busy_start"}, busy, 1);
      for (int i = 0; i < n_exec; i++) begin
         tick(1);
         chk($sformatf("%s_state_exec_%0d", name, i), dbg_state, 2);
         chk($sformatf("%s_alu_a_%0d", name, i), alu_a, exp_acc);
         chk($sformatf("%s_alu_b_%0d", name, i), alu_b, pg[i][W-1:0]);
         chk($sformatf("%s_alu_op_%0d", name, i), alu_op, pg[i][W+1:W]);
         if (poke && i == 2) begin
            start     = 1'b1;
            prog_we   = 1'b1;
            prog_addr = AW'(3);
            prog_data = mk(2'b00, 2'b00, 8'd99);
         end
         tick(1);
         start   = 1'b0;
         prog_we = 1'b0;
         if (pg[i][W+3:W+2] != 2'b10) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("%s_queue_empty_%0d", name, i), 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("%s_acc_%0d", name, i), acc, e);
               exp_acc = e;
            end
         end
         if (i < n_exec - 1) chk($sformatf("%s_no_done_%0d", name, i), done, 0);
      end
      chk({name, "_done_pulse"}, done, 1);
      chk({name, "_done_edge"}, cyc - cyc0, done_edge);
      tick(1);
      chk({name, "_done_low"}, done, 0);
      chk({name, "_idle"}, busy, 0);
      chk({name, "_acc_held"}, acc, exp_acc);
   endtask

   initial begin
      rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
      exp_acc = '0;
      tick(2);
      rst = 1'b0;
      tick(1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_acc", acc, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_state", dbg_state, 0);

      // Reset memory is all HALT.
      pg[0] = mk(2'b10, 2'b00, 8'd0);
      run_prog("empty", 1, 2, 1'b0);

      // Main program, with start/prog_we poked while busy.
      pg[0] = mk(2'b00, 2'd0, 8'd7);
      pg[1] = mk(2'b01, 2'd0, 8'd3);
      pg[2] = mk(2'b01, 2'd1, 8'd3);
      pg[3] = mk(2'b01, 2'd2, 8'd3);
      pg[4] = mk(2'b01, 2'd3, 8'd12);
      pg[5] = mk(2'b10, 2'd0, 8'd0);
      pg_len = 6;
      load_prog();
      exp_q.push_back(8'd7);  exp_q.push_back(8'd10); exp_q.push_back(8'd7);
      exp_q.push_back(8'd3);  exp_q.push_back(8'd15);
      run_prog("main", 6, 12, 1'b1);
      // Same program again: word 3 must be untouched and acc carries over.
      exp_q.push_back(8'd7);  exp_q.push_back(8'd10); exp_q.push_back(8'd7);
      exp_q.push_back(8'd3);  exp_q.push_back(8'd15);
      run_prog("rerun", 6, 12, 1'b0);

      // Wrap-around.
      pg[0] = mk(2'b00, 2'd0, 8'd0);
      pg[1] = mk(2'b01, 2'd1, 8'd1);
      pg[2] = mk(2'b10, 2'd0, 8'd0);
      pg_len = 3;
      load_prog();
      exp_q.push_back(8'd0); exp_q.push_back(8'd255);
      run_prog("wrap_sub", 3, 6, 1'b0);
      pg[0] = mk(2'b00, 2'd0, 8'd250);
      pg[1] = mk(2'b01, 2'd0, 8'd10);
      load_prog();
      exp_q.push_back(8'd250); exp_q.push_back(8'd4);
      run_prog("wrap_add", 3, 6, 1'b0);

      // No HALT: LDI 5 then 15 NOPs with random op/imm.
      pg[0] = mk(2'b00, 2'd0, 8'd5);
      for (int i = 1; i < DEPTH; i++) begin
         pg[i] = mk(2'b11, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end
      pg_len = DEPTH;
      load_prog();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'd5);
      run_prog("nohalt", DEPTH, 2 * DEPTH, 1'b0);

      // Reset during EXEC of instruction 2.
      pg[0] = mk(2'b00, 2'd0, 8'd7);
      pg[1] = mk(2'b01, 2'd0, 8'd3);
      pg[2] = mk(2'b01, 2'd1, 8'd3);
      pg_len = 3;
      load_prog();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(5);
      chk("mid_state_exec", dbg_state, 2);
      chk("mid_acc_before", acc, 10);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_acc", acc, 0);
      chk("mid_rst_alu_b", alu_b, 0);
      tick(1);
      rst = 1'b0;
      exp_acc = '0;
      pg[0] = mk(2'b10, 2'b00, 8'd0);
      run_prog("post_rst", 1, 2, 1'b0);
      chk("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
